// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words, writes them to
// instruction memory, checks an XOR checksum and holds the core in reset until the load verifies.
module imem_loader #(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_byteValid,
    input  logic [7:0]        i_byteData,
    output logic              o_byteReady,
    output logic              o_memWrite,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [31:0]       o_memData,
    output logic              o_cpuRst,
    output logic              o_done,
    output logic              o_error
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0]       LP_MAX = 17'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] LP_ONE = ADDR_W'(1);

    state_t              r_state, w_next;
    logic                r_byteReady, r_memWrite, r_cpuRst, r_done, r_error;
    logic [ADDR_W-1:0]   r_memAddr, r_word_idx, r_last_idx;
    logic [31:0]         r_memData;
    logic [7:0]          r_cnt_hi, r_acc;
    logic [23:0]         r_word;
    logic [1:0]          r_byte_idx;

    logic                w_xfer, w_restart, w_word_end, w_last_word;
    logic [15:0]         w_count;
    logic                w_ready_nxt, w_cpuRst_nxt, w_done_nxt, w_error_nxt;

    assign w_xfer      = i_byteValid && r_byteReady;
    assign w_restart   = i_start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_count     = {r_cnt_hi, i_byteData};
    assign w_word_end  = (r_byte_idx == 2'd3);
    assign w_last_word = (r_word_idx == r_last_idx);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_byteReady <= 1'b0;
            r_cpuRst    <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_byteReady <= w_ready_nxt;
            r_cpuRst    <= w_cpuRst_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (w_restart) w_next = S_HDR_HI;
            S_HDR_HI:              if (w_xfer) w_next = S_HDR_LO;
            S_HDR_LO: begin
                if (w_xfer) begin
                    if ({1'b0, w_count} > LP_MAX) w_next = S_ERR;
                    else if (w_count == 16'd0)    w_next = S_CHK;
                    else                          w_next = S_DATA;
                end
            end
            S_DATA:  if (w_xfer && w_word_end && w_last_word) w_next = S_CHK;
            S_CHK:   if (w_xfer) w_next = (i_byteData == r_acc) ? S_DONE : S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they register in step with it.
    always_comb begin
        w_ready_nxt  = (w_next == S_HDR_HI) || (w_next == S_HDR_LO) ||
                       (w_next == S_DATA)   || (w_next == S_CHK);
        w_done_nxt   = (w_next == S_DONE);
        w_error_nxt  = (w_next == S_ERR);
        w_cpuRst_nxt = (w_next != S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_memWrite <= 1'b0;
            r_memAddr  <= '0;
            r_memData  <= '0;
            r_word_idx <= '0;
            r_last_idx <= '0;
            r_byte_idx <= '0;
            r_cnt_hi   <= '0;
            r_acc      <= '0;
            r_word     <= '0;
        end else begin
            r_memWrite <= 1'b0;
            if (w_restart) begin
                r_word_idx <= '0;
                r_byte_idx <= '0;
                r_acc      <= '0;
            end
            if (w_xfer && r_state == S_HDR_HI) r_cnt_hi <= i_byteData;
            // A count of MAX_WORDS truncates to zero here, so minus one lands on the top address.
            if (w_xfer && r_state == S_HDR_LO) r_last_idx <= w_count[ADDR_W-1:0] - LP_ONE;
            if (w_xfer && r_state == S_DATA) begin
                r_acc      <= r_acc ^ i_byteData;
                r_word     <= {r_word[15:0], i_byteData};
                r_byte_idx <= r_byte_idx + 2'd1;
                if (w_word_end) begin
                    r_memWrite <= 1'b1;
                    r_memAddr  <= r_word_idx;
                    r_memData  <= {r_word, i_byteData};
                    if (!w_last_word) r_word_idx <= r_word_idx + LP_ONE;
                end
            end
        end
    end

    assign o_byteReady = r_byteReady;
    assign o_memWrite  = r_memWrite;
    assign o_memAddr   = r_memAddr;
    assign o_memData   = r_memData;
    assign o_cpuRst    = r_cpuRst;
    assign o_done      = r_done;
    assign o_error     = r_error;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams are parsed by a stream-level model into expected
// writes and outcome; a negedge monitor scores every memWrite for address, data and timing.
module tb_imem_loader;
    localparam int ADDR_W = 12;
    localparam int MAXW   = 4096;

    typedef logic [7:0] bq_t[$];

    logic              i_clk = 1'b0;
    logic              i_rst, i_start, i_byteValid;
    logic [7:0]        i_byteData;
    logic              o_byteReady, o_memWrite, o_cpuRst, o_done, o_error;
    logic [ADDR_W-1:0] o_memAddr;
    logic [31:0]       o_memData;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_byteValid(i_byteValid), .i_byteData(i_byteData),
        .o_byteReady(o_byteReady), .o_memWrite(o_memWrite),
        .o_memAddr(o_memAddr), .o_memData(o_memData),
        .o_cpuRst(o_cpuRst), .o_done(o_done), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_pass = 0;
    int load_id = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Monitor: a write for word k must land in the cycle right after transfer number 6+4k completes.
    int mon_id = 0, wr_idx = 0, xcnt = 0;
    bit prev_x = 0;
    always @(negedge i_clk) begin
        bit cur;
        if (load_id != mon_id) begin
            mon_id = load_id; wr_idx = 0; xcnt = 0; prev_x = 0;
        end
        if (o_memWrite) begin
            if (wr_idx < exp_addr.size()) begin
                check_eq("wr_addr", 32'(o_memAddr), exp_addr[wr_idx]);
                check_eq("wr_data", o_memData, exp_data[wr_idx]);
                check_eq("wr_timing", prev_x ? xcnt : 32'hFFFF_FFFF, 6 + 4 * wr_idx);
            end else begin
                check_eq("extra_wr", wr_idx + 1, exp_addr.size());
            end
            wr_idx++;
        end
        cur    = i_byteValid && o_byteReady && !i_rst;
        xcnt   = xcnt + int'(cur);
        prev_x = cur;
    end

    // Returns 0 = incomplete, 1 = done, 2 = error; fills the expected write list.
    function automatic int model(input bq_t s);
        int n, outc;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        if (s.size() < 2) return 0;
        n = {s[0], s[1]};
        if (n > MAXW) return 2;
        for (int k = 0; k < n; k++)
            if (2 + 4 * k + 3 < s.size()) begin
                exp_addr.push_back(k);
                exp_data.push_back({s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]});
            end
        outc = 0;
        if (s.size() >= 2 + 4 * n + 1) begin
            x = 8'h00;
            for (int i = 2; i < 2 + 4 * n; i++) x ^= s[i];
            outc = (x == s[2 + 4 * n]) ? 1 : 2;
        end
        return outc;
    endfunction

    function automatic bq_t mk_stream(input int n, input bit bad_chk);
        bq_t s;
        logic [7:0] x = 8'h00, b;
        logic [15:0] n16 = 16'(n);
        s.push_back(n16[15:8]);
        s.push_back(n16[7:0]);
        if (n > MAXW) return s;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            s.push_back(b);
            x ^= b;
        end
        if (bad_chk) x ^= 8'(8'h01 << $urandom_range(0, 7));
        s.push_back(x);
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gaps);
        int t = 0;
        repeat (gaps) begin i_byteValid = 1'b0; @(posedge i_clk); #1; end
        i_byteValid = 1'b1;
        i_byteData  = b;
        while (!o_byteReady && t < 50) begin @(posedge i_clk); #1; t++; end
        if (!o_byteReady) begin
            check_eq("rdy_timeout", 32'(o_byteReady), 1);
            i_byteValid = 1'b0;
            return;
        end
        @(posedge i_clk); #1;
        i_byteValid = 1'b0;
    endtask

    // gapmode: 0 none, 1 valid toggles every cycle, 2 random gaps; rst_after<0 means no abort.
    task automatic run_load(input bq_t s, input int gapmode, input int rst_after);
        bq_t pre;
        int outc, gaps;
        for (int i = 0; i < s.size(); i++)
            if (rst_after < 0 || i < rst_after) pre.push_back(s[i]);
        outc = model(pre);
        load_id++;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        foreach (pre[i]) begin
            gaps = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : $urandom_range(0, 2);
            send_byte(pre[i], gaps);
        end
        if (rst_after >= 0) begin
            i_rst = 1'b1;
            @(posedge i_clk); #1;
            i_rst = 1'b0;
            check_eq("abort_memWrite", 32'(o_memWrite), 0);
            check_eq("abort_ready", 32'(o_byteReady), 0);
            check_eq("abort_cpuRst", 32'(o_cpuRst), 1);
            check_eq("abort_done", 32'(o_done), 0);
            check_eq("abort_error", 32'(o_error), 0);
        end else begin
            check_eq("end_done", 32'(o_done), 32'(outc == 1));
            check_eq("end_error", 32'(o_error), 32'(outc == 2));
            check_eq("end_cpuRst", 32'(o_cpuRst), 32'(outc != 1));
            check_eq("end_ready", 32'(o_byteReady), 0);
        end
        // Junk bytes offered outside the receiving states must be ignored.
        i_byteValid = 1'b1;
        i_byteData  = 8'($urandom);
        repeat (3) begin @(posedge i_clk); #1; end
        i_byteValid = 1'b0;
        @(posedge i_clk); #1;
        check_eq("hold_done", 32'(o_done), 32'(rst_after < 0 && outc == 1));
        check_eq("wr_count", wr_idx, exp_addr.size());
    endtask

    initial begin
        bq_t good, s;
        int n;
        good = '{8'h00, 8'h02, 8'h8C, 8'h22, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA};
        i_rst = 1'b1; i_start = 1'b0; i_byteValid = 1'b1; i_byteData = 8'h55;
        repeat (2) begin @(posedge i_clk); #1; end
        check_eq("rst_ready", 32'(o_byteReady), 0);
        check_eq("rst_memWrite", 32'(o_memWrite), 0);
        check_eq("rst_memAddr", 32'(o_memAddr), 0);
        check_eq("rst_memData", o_memData, 0);
        check_eq("rst_cpuRst", 32'(o_cpuRst), 1);
        check_eq("rst_done", 32'(o_done), 0);
        check_eq("rst_error", 32'(o_error), 0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check_eq("idle_ready", 32'(o_byteReady), 0);
        i_byteValid = 1'b0;

        run_load(good, 0, -1);
        if (exp_data.size() == 2) check_eq("model_word0", exp_data[0], 32'h8C22_0004);
        s = good; s[10] = 8'h00;
        run_load(s, 0, -1);
        s = '{8'h10, 8'h01};
        run_load(s, 0, -1);
        s = '{8'h00, 8'h00, 8'h00};
        run_load(s, 0, -1);
        run_load(good, 1, -1);
        run_load(good, 0, 5);
        run_load(good, 2, -1);

        for (int it = 0; it < 24; it++) begin
            n = ($urandom_range(0, 7) == 0) ? MAXW + 1 + $urandom_range(0, 2000) : $urandom_range(0, 6);
            s = mk_stream(n, $urandom_range(0, 3) == 0);
            run_load(s, 2, ($urandom_range(0, 5) == 0) ? $urandom_range(1, s.size()) : -1);
        end

        s = mk_stream(MAXW, 1'b0);
        run_load(s, 0, -1);
        s = mk_stream(MAXW + 1, 1'b0);
        run_load(s, 0, -1);
        run_load(good, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot loader that sits directly upstream of the processor core. It receives a program image as a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words into the instruction memory's write port and verifies an XOR checksum. It holds the core in reset until the whole image has loaded and verified.

## Interface
- ADDR_W, 12, word-address width of instruction memory (matches 12-bit PC)
- MAX_WORDS, 4096, largest accepted word count (2**ADDR_W)

- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a load; honoured only in IDLE, DONE, ERR
- byteValid  in  1  upstream byte present
- byteData  in  8  upstream byte
- byteReady  out  1  loader accepts a byte this cycle
- memWrite  out  1  instruction-memory write strobe, one cycle per word
- memAddr  out  ADDR_W  word address for memWrite
- memData  out  32  instruction word for memWrite
- cpuRst  out  1  reset to processor; high unless the last load succeeded
- done  out  1  image loaded and checksum matched
- error  out  1  load aborted (bad length or checksum)

## Operation
- Byte transfer occurs on any posedge where byteValid && byteReady.
- Stream format: count_hi, count_lo (16-bit word count N, big-endian), then 4*N payload bytes with each word MSB first, then one checksum byte equal to the XOR of all payload bytes. The count bytes are not included in the checksum.
- States: IDLE, HDR_HI, HDR_LO, DATA, CHK, DONE, ERR.
- IDLE/DONE/ERR + start: go to HDR_HI. Clear the word index, byte index, XOR accumulator, done and error. Drive cpuRst=1.
- HDR_HI: on transfer, latch the high byte, go to HDR_LO.
- HDR_LO: on transfer, form N.
  - N > MAX_WORDS: go to ERR.
  - N == 0: go to CHK.
  - Otherwise: go to DATA.
- DATA: each transfer shifts the byte into the word register (MSB first) and XORs it into the accumulator. On the 4th byte of a word, register memData/memAddr=word index and pulse memWrite for the next cycle, then increment the word index. After the 4th byte of word N-1, go to CHK.
- CHK: on transfer, compare byteData to the accumulator. Match: go to DONE. Mismatch: go to ERR.
- DONE: done=1, cpuRst=0, byteReady=0. Stays here until start or rst.
- ERR: error=1, cpuRst=1, byteReady=0. Stays here until start or rst.
- byteReady=1 exactly in HDR_HI, HDR_LO, DATA, CHK.
- start outside IDLE/DONE/ERR is ignored.
- byteValid outside the receiving states is ignored; no byte is consumed.
- The word index never wraps: the N ≤ MAX_WORDS check guarantees the last address is MAX_WORDS-1.
- A new load overwrites only addresses 0..N-1. Memory contents beyond N-1 are untouched.

## Timing
- Reset values: state IDLE, byteReady 0, memWrite 0, memAddr 0, memData 0, cpuRst 1, done 0, error 0. All internal counters and the accumulator are 0.
- rst mid-load: return to IDLE on the next edge. memWrite is 0 from that edge and no pending word is written. cpuRst stays 1.
- All outputs are registered.
- byteReady reflects the current state. The loader accepts a byte every cycle with no bubbles, including the cycle memWrite pulses.
- memWrite is high for exactly one cycle, the cycle after the word's 4th byte transfers. memAddr/memData are valid in that cycle.
- done/error rise, and cpuRst falls, on the edge after the checksum transfer. Any last memWrite has therefore completed before cpuRst deasserts.
- ERR on bad length: entered on the edge after the count_lo transfer. No memWrite occurs.
- Minimum load time: 2 + 4N + 1 transfer cycles, plus 1 cycle to DONE.

## Test plan
- Reset: assert rst for 2 cycles with byteValid=1 → all outputs at reset values, byteReady 0, no memWrite.
- Good load: start, then bytes 00 02 8C 22 00 04 00 00 00 00 AA → memWrite at addr 0 with 0x8C220004, then addr 1 with 0x00000000; done=1, cpuRst=0, error=0.
- Bad checksum: same stream with checksum 0x00 → both writes occur, then error=1, done=0, cpuRst=1.
- Bad length: start, bytes 10 01 → error=1 on the next edge, zero memWrite pulses, byteReady 0.
- Empty image: start, bytes 00 00 00 → done=1, cpuRst=0, no memWrite.
- Backpressure and abort:
  - Repeat the good load with byteValid toggling 1/0 every cycle → identical writes and done.
  - Repeat again with rst pulsed after the 5th byte → IDLE, no further memWrite, cpuRst=1; a subsequent start plus good stream succeeds.
